// File: rtl/nibble_serial_adder_ctrl_if.sv
// Bundle between a wide-add requester, the nibble-serial sequencer and the
// external 4-bit ripple adder.
//   start/op_a/op_b/cin      : request and operands (requester -> sequencer)
//   busy/done/sum/cout/ovf   : status and result     (sequencer -> requester)
//   add_a/add_b/add_c0       : adder operand drive   (sequencer -> adder)
//   add_s/add_c4             : adder result          (adder -> sequencer)
// The slave modport is the sequencer. The master modport is its environment.
interface nibble_serial_adder_ctrl_if #(
    parameter int unsigned NIBBLES = 4
);
    localparam int unsigned W = 4 * NIBBLES;

    logic         start;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic         cin;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    logic [3:0]   add_a;
    logic [3:0]   add_b;
    logic         add_c0;
    logic [3:0]   add_s;
    logic         add_c4;

    modport slave (
        input  start, op_a, op_b, cin, add_s, add_c4,
        output busy, done, sum, cout, ovf, add_a, add_b, add_c0
    );

    modport master (
        output start, op_a, op_b, cin, add_s, add_c4,
        input  busy, done, sum, cout, ovf, add_a, add_b, add_c0
    );
endinterface

// File: rtl/nibble_serial_adder_ctrl.sv
// Nibble-serial wide adder sequencer. It streams one nibble of each operand
// per clock through an external combinational 4-bit adder, and chains the
// carry between nibbles. It assembles the W-bit sum and reports it with a
// start/done handshake.
//   clk  : system clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : slave side of nibble_serial_adder_ctrl_if (request, result, adder)
module nibble_serial_adder_ctrl #(
    parameter int unsigned NIBBLES = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    nibble_serial_adder_ctrl_if.slave    bus
);
    localparam int unsigned W  = 4 * NIBBLES;
    localparam int unsigned WW = W - 4;
    localparam int unsigned IW = (NIBBLES > 2) ? $clog2(NIBBLES) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t        state;
    logic [IW-1:0] idx;
    logic [WW-1:0] a_sh;       // nibbles still to be issued for A, the next nibble is in the low 4 bits
    logic [WW-1:0] b_sh;
    logic          a_msb;      // operand sign bits, used for the overflow check
    logic          b_msb;
    logic [WW-1:0] work;       // lower result nibbles, shifted in from the top
    logic [W-1:0]  sum_q;
    logic          cout_q;
    logic          ovf_q;
    logic          busy_q;
    logic          done_q;
    logic [3:0]    add_a_q;
    logic [3:0]    add_b_q;
    logic          add_c0_q;   // also serves as the inter-nibble carry register

    logic last_c;
    assign last_c = (idx == IW'(NIBBLES - 1));

    // Sequencer. The adder drives are registered one nibble ahead, so the
    // adder always sees the slice for the current index.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            idx      <= '0;
            a_sh     <= '0;
            b_sh     <= '0;
            a_msb    <= 1'b0;
            b_msb    <= 1'b0;
            work     <= '0;
            sum_q    <= '0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            add_a_q  <= '0;
            add_b_q  <= '0;
            add_c0_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        a_sh     <= bus.op_a[W-1:4];
                        b_sh     <= bus.op_b[W-1:4];
                        a_msb    <= bus.op_a[W-1];
                        b_msb    <= bus.op_b[W-1];
                        add_a_q  <= bus.op_a[3:0];
                        add_b_q  <= bus.op_b[3:0];
                        add_c0_q <= bus.cin;
                        idx      <= '0;
                        busy_q   <= 1'b1;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    if (last_c) begin
                        sum_q    <= {bus.add_s, work};
                        cout_q   <= bus.add_c4;
                        ovf_q    <= (a_msb == b_msb) && (bus.add_s[3] != a_msb);
                        add_a_q  <= '0;
                        add_b_q  <= '0;
                        add_c0_q <= 1'b0;
                        done_q   <= 1'b1;
                        state    <= DONE;
                    end else begin
                        work     <= WW'({bus.add_s, work} >> 4);
                        add_a_q  <= a_sh[3:0];
                        add_b_q  <= b_sh[3:0];
                        a_sh     <= WW'(a_sh >> 4);
                        b_sh     <= WW'(b_sh >> 4);
                        add_c0_q <= bus.add_c4;
                        idx      <= idx + IW'(1);
                    end
                end
                DONE: begin
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.sum    = sum_q;
    assign bus.cout   = cout_q;
    assign bus.ovf    = ovf_q;
    assign bus.add_a  = add_a_q;
    assign bus.add_b  = add_b_q;
    assign bus.add_c0 = add_c0_q;
endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// Self-checking bench for nibble_serial_adder_ctrl (NIBBLES=4). Models the
// external 4-bit adder. Checks directed vectors and random operands against
// an arithmetic reference, and adds hand-written start-while-busy and
// mid-run reset sequences.
module tb_nibble_serial_adder_ctrl;
    localparam int unsigned NIB = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;

    nibble_serial_adder_ctrl_if #(.NIBBLES(NIB)) bus ();

    nibble_serial_adder_ctrl #(.NIBBLES(NIB)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // External combinational ripple adder.
    assign {bus.add_c4, bus.add_s} = 5'(bus.add_a) + 5'(bus.add_b) + 5'(bus.add_c0);

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        c;
        logic [15:0] s;
        logic        co;
        logic        ov;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference: full-width unsigned add with carry-out.
    function automatic logic [16:0] ref_add(input logic [15:0] a, input logic [15:0] b, input logic c);
        return 17'(a) + 17'(b) + 17'(c);
    endfunction

    // Reference: signed result outside the 16-bit two's-complement range.
    function automatic logic ref_ovf(input logic [15:0] a, input logic [15:0] b, input logic c);
        int s;
        s = int'($signed(a)) + int'($signed(b)) + int'(c);
        return (s > 32767) || (s < -32768);
    endfunction

    // Carry entering nibble i equals the carry out of the low 4*i bits.
    function automatic logic carry_in(input logic [15:0] a, input logic [15:0] b, input logic c, input int i);
        longint m;
        m = longint'(1) << (4 * i);
        return ((longint'(a) % m + longint'(b) % m + longint'(c)) / m) != 0;
    endfunction

    // One full operation, entered at a negedge in IDLE and left at the
    // negedge of the IDLE cycle that follows done.
    task automatic do_add(input logic [15:0] a, input logic [15:0] b, input logic c,
                          input logic [15:0] es, input logic ec, input logic eo, input string tag);
        logic [3:0] na, nb;
        bus.op_a  = a;
        bus.op_b  = b;
        bus.cin   = c;
        bus.start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        for (int i = 0; i < int'(NIB); i++) begin
            na = 4'((a >> (4 * i)) & 16'hF);
            nb = 4'((b >> (4 * i)) & 16'hF);
            chk({tag, " drive"}, {23'd0, bus.add_a, bus.add_b, bus.add_c0},
                {23'd0, na, nb, carry_in(a, b, c, i)});
            chk({tag, " run busy/done"}, {30'd0, bus.busy, bus.done}, 32'd2);
            @(negedge clk);
        end
        chk({tag, " done busy/done"}, {30'd0, bus.busy, bus.done}, 32'd3);
        chk({tag, " sum"}, {16'd0, bus.sum}, {16'd0, es});
        chk({tag, " cout/ovf"}, {30'd0, bus.cout, bus.ovf}, {30'd0, ec, eo});
        chk({tag, " done drive"}, {23'd0, bus.add_a, bus.add_b, bus.add_c0}, 32'd0);
        @(negedge clk);
        chk({tag, " idle busy/done"}, {30'd0, bus.busy, bus.done}, 32'd0);
        chk({tag, " sum hold"}, {16'd0, bus.sum}, {16'd0, es});
    endtask

    initial begin
        vec_t        tbl[6];
        logic [15:0] ra, rb;
        logic        rc;
        logic [16:0] rs;
        int          n_done;
        bit          seen;

        tbl[0] = '{16'h1234, 16'h1111, 1'b0, 16'h2345, 1'b0, 1'b0};
        tbl[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
        tbl[2] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
        tbl[3] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
        tbl[4] = '{16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0, 1'b0};
        tbl[5] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0};

        bus.start = 1'b0;
        bus.op_a  = '0;
        bus.op_b  = '0;
        bus.cin   = 1'b0;

        #1 rst = 1'b1;
        #2;
        chk("reset status", {27'd0, bus.busy, bus.done, bus.cout, bus.ovf, 1'b0}, 32'd0);
        chk("reset sum", {16'd0, bus.sum}, 32'd0);
        chk("reset drive", {23'd0, bus.add_a, bus.add_b, bus.add_c0}, 32'd0);
        #19 rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 6; i++)
            do_add(tbl[i].a, tbl[i].b, tbl[i].c, tbl[i].s, tbl[i].co, tbl[i].ov, $sformatf("vec%0d", i));

        for (int i = 0; i < 24; i++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            rc = 1'($urandom_range(1, 0));
            rs = ref_add(ra, rb, rc);
            do_add(ra, rb, rc, rs[15:0], rs[16], ref_ovf(ra, rb, rc), $sformatf("rnd%0d", i));
        end

        // start while busy is ignored, and late operand changes have no effect
        bus.op_a  = 16'h0F0F;
        bus.op_b  = 16'h00F1;
        bus.cin   = 1'b0;
        bus.start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        n_done = 0;
        @(negedge clk);
        bus.start = 1'b1;
        bus.op_a  = 16'hAAAA;
        bus.op_b  = 16'h5555;
        seen = 1'b0;
        for (int t = 0; t < 10 && !seen; t++) begin
            if (bus.done) begin
                seen = 1'b1;
                n_done++;
                chk("busy-start sum", {16'd0, bus.sum}, 32'h1000);
                chk("busy-start cout", {31'd0, bus.cout}, 32'd0);
            end else begin
                @(negedge clk);
            end
        end
        chk("busy-start done seen", {31'd0, seen}, 32'd1);
        @(negedge clk);
        if (bus.done) n_done++;
        chk("busy-start idle", {31'd0, bus.busy}, 32'd0);
        chk("busy-start one done", n_done, 32'd1);
        @(negedge clk);
        chk("held start accepted", {31'd0, bus.busy}, 32'd1);
        chk("held start drive", {23'd0, bus.add_a, bus.add_b, bus.add_c0}, {23'd0, 4'hA, 4'h5, 1'b0});
        bus.start = 1'b0;
        seen = 1'b0;
        for (int t = 0; t < 10 && !seen; t++) begin
            @(negedge clk);
            if (bus.done) seen = 1'b1;
        end
        chk("second op done seen", {31'd0, seen}, 32'd1);
        chk("second op sum", {16'd0, bus.sum}, 32'hFFFF);
        chk("second op cout/ovf", {30'd0, bus.cout, bus.ovf}, 32'd0);
        @(negedge clk);

        // asynchronous reset in the middle of RUN
        bus.op_a  = 16'h1234;
        bus.op_b  = 16'h4321;
        bus.start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("midrst busy/done", {30'd0, bus.busy, bus.done}, 32'd0);
        chk("midrst sum", {16'd0, bus.sum}, 32'd0);
        chk("midrst drive", {23'd0, bus.add_a, bus.add_b, bus.add_c0}, 32'd0);
        @(negedge clk);
        #3 rst = 1'b0;
        n_done = 0;
        for (int t = 0; t < 8; t++) begin
            @(negedge clk);
            if (bus.done || bus.busy) n_done++;
        end
        chk("midrst no done", n_done, 32'd0);
        do_add(16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0, "post-rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
